seg_scan_mux: RTL and testbench

- Upstream stage of the 7-segment hex decoder.
- Captures a 16-bit display value plus four decimal points.
- Time-multiplexes the value across four digits, presenting one 4-bit nibble, its decimal point and a one-hot digit enable at a time.
- Inserts a dead-time gap between digits to suppress ghosting, and swaps in new values only at frame boundaries so a frame never shows a torn value.

---
 rtl/seg_scan_mux_if.sv | 22 ++
 rtl/seg_scan_mux.sv | 124 ++++++++++++
 tb/tb_seg_scan_mux.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_mux_if.sv
// Bus bundle for seg_scan_mux: display value/write strobe in, scanned digit out.
// The master side drives value/dp_in/value_wr; the slave side is the scanner itself.
interface seg_scan_mux_if;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        value_wr;
    logic [3:0]  nibble;
    logic        dp_out;
    logic [3:0]  digit_en;
    logic        blank;
    logic        frame_done;

    modport master (
        output value, dp_in, value_wr,
        input  nibble, dp_out, digit_en, blank, frame_done
    );

    modport slave (
        input  value, dp_in, value_wr,
        output nibble, dp_out, digit_en, blank, frame_done
    );
endinterface

// File: rtl/seg_scan_mux.sv
// Four-digit time-multiplexed scanner with per-slot dead time and frame-aligned value swap.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading zero digits 1..3.
module seg_scan_mux #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic          clk,
    input  logic          rst_n,
    seg_scan_mux_if.slave bus
);

    localparam int                CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_LIT  = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic [19:0]      r_pend_val;
    logic             r_pend;
    logic [19:0]      r_shadow;
    logic             r_frame_done;

    logic             w_slot_end;
    logic             w_frame_wrap;
    logic [19:0]      w_wr_word;
    logic [3:0]       w_nibble;
    logic             w_dp;
    logic [3:0]       w_onehot;
    logic             w_suppress;
    logic             w_lit;
    logic [3:0]       w_digit_en;

    assign w_slot_end   = (r_cnt == CNT_LAST);
    assign w_frame_wrap = w_slot_end && (r_idx == 2'd3);
    assign w_wr_word    = {bus.dp_in, bus.value};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // A write landing on the wrap cycle goes straight to the shadow and drops any older pending word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_val <= '0;
            r_pend     <= 1'b0;
            r_shadow   <= '0;
        end else if (w_frame_wrap && bus.value_wr) begin
            r_shadow   <= w_wr_word;
            r_pend_val <= w_wr_word;
            r_pend     <= 1'b0;
        end else if (w_frame_wrap && r_pend) begin
            r_shadow   <= r_pend_val;
            r_pend     <= 1'b0;
        end else if (bus.value_wr) begin
            r_pend_val <= w_wr_word;
            r_pend     <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame_wrap;
        end
    end

    always_comb begin
        w_nibble = r_shadow[3:0];
        w_dp     = r_shadow[16];
        case (r_idx)
            2'd1: begin
                w_nibble = r_shadow[7:4];
                w_dp     = r_shadow[17];
            end
            2'd2: begin
                w_nibble = r_shadow[11:8];
                w_dp     = r_shadow[18];
            end
            2'd3: begin
                w_nibble = r_shadow[15:12];
                w_dp     = r_shadow[19];
            end
            default: begin
                w_nibble = r_shadow[3:0];
                w_dp     = r_shadow[16];
            end
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Digit i is a leading zero when it and every more significant nibble are zero.
    always_comb begin
        w_suppress = 1'b0;
        case (r_idx)
            2'd1:    w_suppress = (r_shadow[15:4]  == 12'h000);
            2'd2:    w_suppress = (r_shadow[15:8]  == 8'h00);
            2'd3:    w_suppress = (r_shadow[15:12] == 4'h0);
            default: w_suppress = 1'b0;
        endcase
    end
`else
    assign w_suppress = 1'b0;
`endif

    assign w_onehot   = 4'b0001 << r_idx;
    assign w_lit      = (r_cnt >= CNT_LIT) && !w_suppress;
    assign w_digit_en = w_lit ? w_onehot : 4'b0000;

    assign bus.nibble     = w_nibble;
    assign bus.dp_out     = w_dp & ~w_suppress;
    assign bus.digit_en   = w_digit_en;
    assign bus.blank      = ~|w_digit_en;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with REFRESH_DIV=8, BLANK_CYCLES=2.
// Cycle c means the state after c rising edges since reset release; sampling is on the falling edge.
module tb_seg_scan_mux;

    localparam int RD = 8;
    localparam int BC = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    seg_scan_mux_if bus ();

    seg_scan_mux #(
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] nibOf(logic [15:0] v, int d);
        logic [15:0] t;
        t = v >> (4 * d);
        return t[3:0];
    endfunction

    // Expected enable for cycle c while the shown value is v.
    function automatic logic [3:0] expEn(int c, logic [15:0] v);
        int d;
        logic [15:0] t;
        d = (c / RD) % 4;
        t = v >> (4 * d);
        if ((c % RD) < BC) return 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && t == 16'h0000) return 4'b0000;
`endif
        return 4'b0001 << d;
    endfunction

    task tick;
        @(negedge clk);
    endtask

    task doReset;
        bus.value_wr = 1'b0;
        bus.value    = 16'h0000;
        bus.dp_in    = 4'b0000;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task test_reset;
        doReset();
        for (int c = 0; c < 42; c++) begin
            bus.value_wr = (c == 0);
            bus.value    = 16'hFFFF;
            bus.dp_in    = 4'hF;
            tick();
        end
        bus.value_wr = 1'b0;
        tests++;
        if (bus.nibble !== 4'hF) begin
            fails++;
            $display("[TB] FAIL reset_pre_nibble got=%h exp=%h", bus.nibble, 4'hF);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (bus.digit_en !== 4'b0000) begin
            fails++;
            $display("[TB] FAIL reset_digit_en got=%b exp=0000", bus.digit_en);
        end
        tests++;
        if (bus.blank !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_blank got=%b exp=1", bus.blank);
        end
        tests++;
        if (bus.nibble !== 4'h0) begin
            fails++;
            $display("[TB] FAIL reset_nibble got=%h exp=0", bus.nibble);
        end
        tests++;
        if (bus.dp_out !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_dp_out got=%b exp=0", bus.dp_out);
        end
        tests++;
        if (bus.frame_done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_frame_done got=%b exp=0", bus.frame_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task test_idle_timeline;
        doReset();
        for (int c = 0; c < 41; c++) begin
            tests++;
            if (bus.digit_en !== expEn(c, 16'h0000)) begin
                fails++;
                $display("[TB] FAIL idle_digit_en cyc=%0d got=%b exp=%b", c, bus.digit_en, expEn(c, 16'h0000));
            end
            tests++;
            if (bus.blank !== (expEn(c, 16'h0000) == 4'b0000)) begin
                fails++;
                $display("[TB] FAIL idle_blank cyc=%0d got=%b", c, bus.blank);
            end
            tests++;
            if (bus.frame_done !== (c == 32)) begin
                fails++;
                $display("[TB] FAIL idle_frame_done cyc=%0d got=%b exp=%b", c, bus.frame_done, (c == 32));
            end
            tests++;
            if (bus.nibble !== 4'h0 || bus.dp_out !== 1'b0) begin
                fails++;
                $display("[TB] FAIL idle_nibble cyc=%0d got=%h/%b exp=0/0", c, bus.nibble, bus.dp_out);
            end
            tick();
        end
    endtask

    task test_write_latency;
        logic [15:0] shown;
        logic [3:0]  expNib;
        logic        expDp;
        doReset();
        for (int c = 0; c < 64; c++) begin
            bus.value_wr = (c == 5);
            bus.value    = (c == 5) ? 16'hA5C3 : 16'h0000;
            bus.dp_in    = (c == 5) ? 4'b0100 : 4'b0000;
            shown  = (c < 32) ? 16'h0000 : 16'hA5C3;
            expNib = nibOf(shown, (c / RD) % 4);
            expDp  = (c >= 32) && ((c / RD) % 4 == 2);
            tests++;
            if (bus.nibble !== expNib) begin
                fails++;
                $display("[TB] FAIL latency_nibble cyc=%0d got=%h exp=%h", c, bus.nibble, expNib);
            end
            tests++;
            if (bus.dp_out !== expDp) begin
                fails++;
                $display("[TB] FAIL latency_dp cyc=%0d got=%b exp=%b", c, bus.dp_out, expDp);
            end
            tests++;
            if (bus.digit_en !== expEn(c, shown)) begin
                fails++;
                $display("[TB] FAIL latency_digit_en cyc=%0d got=%b exp=%b", c, bus.digit_en, expEn(c, shown));
            end
            tick();
        end
        bus.value_wr = 1'b0;
    endtask

    task test_last_write_wins;
        logic [3:0] expNib;
        doReset();
        for (int c = 0; c < 64; c++) begin
            bus.value_wr = (c == 3) || (c == 10);
            bus.value    = (c == 3) ? 16'h1111 : 16'h2222;
            bus.dp_in    = 4'b0000;
            expNib = (c < 32) ? 4'h0 : 4'h2;
            tests++;
            if (bus.nibble !== expNib) begin
                fails++;
                $display("[TB] FAIL last_write_nibble cyc=%0d got=%h exp=%h", c, bus.nibble, expNib);
            end
            tick();
        end
        bus.value_wr = 1'b0;
    endtask

    task test_wrap_write;
        logic [3:0] expNib;
        doReset();
        for (int c = 0; c < 96; c++) begin
            bus.value_wr = (c == 4) || (c == 31);
            bus.value    = (c == 4) ? 16'h1111 : 16'h0BEE;
            bus.dp_in    = 4'b0000;
            expNib = (c < 32) ? 4'h0 : nibOf(16'h0BEE, (c / RD) % 4);
            tests++;
            if (bus.nibble !== expNib) begin
                fails++;
                $display("[TB] FAIL wrap_write_nibble cyc=%0d got=%h exp=%h", c, bus.nibble, expNib);
            end
            tick();
        end
        bus.value_wr = 1'b0;
    endtask

    task test_midframe_reset;
        logic [3:0] expNib;
        doReset();
        for (int c = 0; c <= 52; c++) begin
            bus.value_wr = (c == 2);
            bus.value    = 16'h1234;
            bus.dp_in    = 4'b0000;
            expNib = (c < 32) ? 4'h0 : nibOf(16'h1234, (c / RD) % 4);
            tests++;
            if (bus.nibble !== expNib) begin
                fails++;
                $display("[TB] FAIL midreset_pre_nibble cyc=%0d got=%h exp=%h", c, bus.nibble, expNib);
            end
            if (c < 52) tick();
        end
        bus.value_wr = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (bus.nibble !== 4'h0 || bus.digit_en !== 4'b0000 || bus.blank !== 1'b1) begin
            fails++;
            $display("[TB] FAIL midreset_async got=%h/%b/%b exp=0/0000/1", bus.nibble, bus.digit_en, bus.blank);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 41; c++) begin
            tests++;
            if (bus.digit_en !== expEn(c, 16'h0000) || bus.nibble !== 4'h0) begin
                fails++;
                $display("[TB] FAIL midreset_restart cyc=%0d got=%b/%h exp=%b/0", c, bus.digit_en, bus.nibble, expEn(c, 16'h0000));
            end
            tests++;
            if (bus.frame_done !== (c == 32)) begin
                fails++;
                $display("[TB] FAIL midreset_frame_done cyc=%0d got=%b exp=%b", c, bus.frame_done, (c == 32));
            end
            tick();
        end
    endtask

`ifdef LEADING_ZERO_BLANK_EN
    task test_leading_zero;
        logic [3:0] expD;
        doReset();
        for (int c = 0; c < 64; c++) begin
            bus.value_wr = (c == 1);
            bus.value    = 16'h0040;
            bus.dp_in    = 4'b1111;
            if (c >= 32) begin
                expD = (((c % RD) >= BC) && ((c / RD) % 4 <= 1)) ? (4'b0001 << ((c / RD) % 4)) : 4'b0000;
                tests++;
                if (bus.digit_en !== expD || bus.blank !== (expD == 4'b0000)) begin
                    fails++;
                    $display("[TB] FAIL lzb_digit_en cyc=%0d got=%b/%b exp=%b", c, bus.digit_en, bus.blank, expD);
                end
            end
            tick();
        end
        bus.value_wr = 1'b0;
    endtask
`endif

    initial begin
        bus.value    = 16'h0000;
        bus.dp_in    = 4'b0000;
        bus.value_wr = 1'b0;
        test_reset();
        test_idle_timeline();
        test_write_latency();
        test_last_write_wins();
        test_wrap_write();
        test_midframe_reset();
`ifdef LEADING_ZERO_BLANK_EN
        test_leading_zero();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
